gate_vector_checker: RTL

Self-test stage for the 2-input gate: drives the gate's `a`/`b` inputs through the full truth table, waits a programmable settle time, samples the returned `y` and compares it against the expected NAND value (`y = ~(a & b)`). It sits around the gate as upstream stimulus source and downstream result consumer. It reports pass/fail, a saturating mismatch count and the first failing vector.

---
 rtl/gate_chk_pkg.sv | 19 +
 rtl/gate_chk_settle_timer.sv | 36 +++
 rtl/gate_vector_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the NAND-gate self-test stage.
// Holds the FSM state encoding, the vector sweep order and the reference gate function.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Indexed by the vector index; each entry is {a,b}.
   localparam logic [1:0] VEC_ORDER [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

   function automatic logic expected_y(input logic a, input logic b);
      return ~(a & b);
   endfunction

endpackage

// File: rtl/gate_chk_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// The counter stops at zero; zero is flagged combinationally from the register.
module gate_chk_settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Self-test stage for a 2-input NAND gate: sweeps the truth table, samples y after a
// settle window and reports pass/fail, a saturating mismatch count and the first bad vector.
module gate_vector_checker #(
   parameter int SETTLE = 2,
   parameter int PASSES = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_out,
   output logic             b_out,
   input  logic             y_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [1:0]       fail_vec
);

   import gate_chk_pkg::*;

   localparam int             TW        = $clog2(SETTLE) + 1;
   localparam logic [TW-1:0]  SETTLE_LD = TW'(SETTLE - 1);
   localparam int             PCW       = $clog2(PASSES + 1);
   localparam logic [PCW-1:0] PASSES_V  = PCW'(PASSES);

   state_e           state_q,      state_d;
   logic [1:0]       idx_q,        idx_d;
   logic [PCW-1:0]   pass_cnt_q,   pass_cnt_d;
   logic             a_out_q,      a_out_d;
   logic             b_out_q,      b_out_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;
   logic             pass_q,       pass_d;
   logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
   logic             fail_valid_q, fail_valid_d;
   logic [1:0]       fail_vec_q,   fail_vec_d;

   logic             timer_load;
   logic             timer_dec;
   logic             timer_zero;
   logic             mismatch;
   logic [1:0]       vec_d;

   gate_chk_settle_timer #(
      .W (TW)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (SETTLE_LD),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      idx_d        = idx_q;
      pass_cnt_d   = pass_cnt_q;
      pass_d       = pass_q;
      err_cnt_d    = err_cnt_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      mismatch     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_DRIVE;
               idx_d        = 2'd0;
               pass_cnt_d   = '0;
               pass_d       = 1'b0;
               err_cnt_d    = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = 2'b00;
               timer_load   = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (timer_zero) begin
               state_d = ST_SAMPLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_SAMPLE: begin
            // The pins still carry the vector under test during this cycle.
            mismatch = (y_in != expected_y(a_out_q, b_out_q));
            if (mismatch) begin
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + CNT_W'(1);
               end
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_vec_d   = {a_out_q, b_out_q};
               end
            end
            idx_d   = idx_q + 2'd1;
            state_d = ST_DRIVE;
            if (idx_q == 2'd3) begin
               pass_cnt_d = pass_cnt_q + PCW'(1);
               if (pass_cnt_d == PASSES_V) begin
                  state_d = ST_DONE;
                  pass_d  = (err_cnt_d == '0);
               end
            end
            timer_load = (state_d == ST_DRIVE);
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with the state register.
      busy_d  = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
      done_d  = (state_d == ST_DONE);
      vec_d   = busy_d ? VEC_ORDER[idx_d] : 2'b00;
      a_out_d = vec_d[1];
      b_out_d = vec_d[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         pass_cnt_q   <= '0;
         a_out_q      <= 1'b0;
         b_out_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         idx_q        <= idx_d;
         pass_cnt_q   <= pass_cnt_d;
         a_out_q      <= a_out_d;
         b_out_q      <= b_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
      end
   end

   assign a_out      = a_out_q;
   assign b_out      = b_out_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule
